// File: rtl/rx_pkg.sv
// Shared receive/transmit lane definitions: FSM states, COM idle symbol and
// the default alignment parameters used by both serializer directions.
package rx_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    ACTIVE  = 2'd2
  } rx_state_e;

  localparam logic [7:0]  COM_SYMBOL        = 8'hBC;
  localparam int          WORD_WIDTH        = 32;
  localparam logic [31:0] COM_WORD_DEFAULT  = {4{COM_SYMBOL}};
  localparam int          COM_COUNT_DEFAULT = 4;

endpackage : rx_pkg

// File: rtl/serial_to_parallel_c_com_detector.sv
// Serial-in shift register with a combinational look-ahead compare of the
// word that will be held after the current edge against the COM idle word.
module com_detector #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] COM_WORD = {(WIDTH/8){8'hBC}}
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             data_i,
  output logic [WIDTH-1:0] sr_next_o,
  output logic             match_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // MSB-first: the newest bit always enters at bit 0.
  assign sr_d      = {sr_q[WIDTH-2:0], data_i};
  assign sr_next_o = sr_d;
  assign match_o   = (sr_d == COM_WORD);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule : com_detector

// File: rtl/serial_to_parallel_c.sv
// Per-lane deserializer: bit-granular COM hunt, word-aligned lock counting,
// then one registered data word (with valid) per WIDTH-bit word period.
module serial_to_parallel_c
  import rx_pkg::*;
#(
  parameter int               WIDTH     = WORD_WIDTH,
  parameter logic [WIDTH-1:0] COM_WORD  = COM_WORD_DEFAULT,
  parameter int               COM_COUNT = COM_COUNT_DEFAULT
) (
  input  logic             clk_32f_c,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active
);

  localparam int BIT_CNT_W = $clog2(WIDTH);
  localparam int COM_CNT_W = $clog2(COM_COUNT + 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(WIDTH - 1);
  localparam logic [COM_CNT_W-1:0] COM_ONE   = COM_CNT_W'(1);
  localparam logic [COM_CNT_W-1:0] COM_FINAL = COM_CNT_W'(COM_COUNT - 1);

  rx_state_e             state_q;
  logic [BIT_CNT_W-1:0]  bit_cnt_q;
  logic [BIT_CNT_W-1:0]  bit_cnt_d;
  logic [COM_CNT_W-1:0]  com_cnt_q;
  logic [WIDTH-1:0]      data_out_q;
  logic                  valid_q;
  logic                  active_q;

  logic [WIDTH-1:0]      sr_next;
  logic                  com_match;
  logic                  word_done;

  com_detector #(
    .WIDTH    (WIDTH),
    .COM_WORD (COM_WORD)
  ) u_com_detector (
    .clk_i     (clk_32f_c),
    .rst_ni    (reset),
    .data_i    (data_in),
    .sr_next_o (sr_next),
    .match_o   (com_match)
  );

  always_comb begin
    word_done = (bit_cnt_q == BIT_LAST);
    bit_cnt_d = word_done ? '0 : bit_cnt_q + BIT_CNT_W'(1);
  end

  always_ff @(posedge clk_32f_c or negedge reset) begin
    if (!reset) begin
      state_q    <= SEARCH;
      bit_cnt_q  <= '0;
      com_cnt_q  <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      case (state_q)
        SEARCH: begin
          // A match here defines the word boundary, so the counter restarts.
          if (com_match) begin
            bit_cnt_q <= '0;
            com_cnt_q <= COM_ONE;
            if (COM_COUNT == 1) begin
              state_q  <= ACTIVE;
              active_q <= 1'b1;
            end else begin
              state_q <= LOCKING;
            end
          end
        end

        LOCKING: begin
          bit_cnt_q <= bit_cnt_d;
          if (word_done) begin
            if (com_match) begin
              com_cnt_q <= com_cnt_q + COM_ONE;
              if (com_cnt_q == COM_FINAL) begin
                state_q  <= ACTIVE;
                active_q <= 1'b1;
              end
            end else begin
              com_cnt_q <= '0;
              bit_cnt_q <= '0;
              state_q   <= SEARCH;
            end
          end
        end

        ACTIVE: begin
          bit_cnt_q <= bit_cnt_d;
          // Idle COM words are suppressed; outputs hold for a full word period.
          if (word_done) begin
            if (com_match) begin
              data_out_q <= '0;
              valid_q    <= 1'b0;
            end else begin
              data_out_q <= sr_next;
              valid_q    <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= SEARCH;
        end
      endcase
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_q;
  assign active    = active_q;

endmodule : serial_to_parallel_c

// File: tb/tb_serial_to_parallel_c.sv
// Directed bench: a table of serial bursts with expected outputs after each
// burst, plus a hand-written asynchronous mid-word reset sequence.
module tb_serial_to_parallel_c;

  localparam logic [31:0] COM = 32'hBCBCBCBC;

  logic        clk_32f_c;
  logic        reset;
  logic        data_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic        active;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       name;
    bit          do_reset;
    logic [31:0] bits;
    int          nbits;
    logic [31:0] exp_data;
    logic        exp_valid;
    logic        exp_active;
  } vec_t;

  vec_t vecs[$];

  serial_to_parallel_c dut (
    .clk_32f_c (clk_32f_c),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active)
  );

  initial clk_32f_c = 1'b0;
  always #5 clk_32f_c = ~clk_32f_c;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic check_outs(input string name, input logic [31:0] d, input logic v, input logic a);
    check({name, ".data_out"},  data_out, d);
    check({name, ".valid_out"}, {31'd0, valid_out}, {31'd0, v});
    check({name, ".active"},    {31'd0, active}, {31'd0, a});
  endtask

  // Drives bits[n-1] first; each bit is applied 1 time unit after an edge.
  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      data_in = bits[i];
      @(posedge clk_32f_c);
      #1;
    end
  endtask

  task automatic apply_reset();
    data_in = 1'b0;
    reset   = 1'b0;
    repeat (2) @(posedge clk_32f_c);
    #1;
    reset = 1'b1;
  endtask

  function automatic void add(input string name, input bit rst, input logic [31:0] bits,
                              input int n, input logic [31:0] d, input logic v, input logic a);
    vec_t t;
    t.name = name; t.do_reset = rst; t.bits = bits; t.nbits = n;
    t.exp_data = d; t.exp_valid = v; t.exp_active = a;
    vecs.push_back(t);
  endfunction

  initial begin
    // Lock sequence after 31 leading zeros, then data, hold and COM suppression.
    add("t2_com1",      0, COM,      32, 32'h0, 0, 0);
    add("t2_com2",      0, COM,      32, 32'h0, 0, 0);
    add("t2_com3",      0, COM,      32, 32'h0, 0, 0);
    add("t2_com4_pre",  0, COM >> 1, 31, 32'h0, 0, 0);
    add("t2_com4_last", 0, COM & 32'h1, 1, 32'h0, 0, 1);
    add("t2_deadbeef",  0, 32'hDEADBEEF, 32, 32'hDEADBEEF, 1, 1);
    add("t5_hold",      0, 32'hCAFEF00D >> 1, 31, 32'hDEADBEEF, 1, 1);
    add("t5_cafe",      0, 32'h1, 1, 32'hCAFEF00D, 1, 1);
    add("t5_com",       0, COM,      32, 32'h0, 0, 1);
    // Lock from an arbitrary bit offset.
    add("t3_offset",    1, 32'h16,    5, 32'h0, 0, 0);
    add("t3_com1",      0, COM,      32, 32'h0, 0, 0);
    add("t3_com2",      0, COM,      32, 32'h0, 0, 0);
    add("t3_com3",      0, COM,      32, 32'h0, 0, 0);
    add("t3_com4_pre",  0, COM >> 1, 31, 32'h0, 0, 0);
    add("t3_com4_last", 0, COM & 32'h1, 1, 32'h0, 0, 1);
    add("t3_data",      0, 32'h12345678, 32, 32'h12345678, 1, 1);
    // A bad word during LOCKING restarts the hunt.
    add("t4_com1",      1, COM,      32, 32'h0, 0, 0);
    add("t4_com2",      0, COM,      32, 32'h0, 0, 0);
    add("t4_bad",       0, 32'h00FF00FF, 32, 32'h0, 0, 0);
    add("t4_com_a",     0, COM,      32, 32'h0, 0, 0);
    add("t4_com_b",     0, COM,      32, 32'h0, 0, 0);
    add("t4_com_c",     0, COM,      32, 32'h0, 0, 0);
    add("t4_com_d_pre", 0, COM >> 1, 31, 32'h0, 0, 0);
    add("t4_com_d_last",0, COM & 32'h1, 1, 32'h0, 0, 1);
    add("t4_data",      0, 32'hA5A55A5A, 32, 32'hA5A55A5A, 1, 1);

    // Reset held while data toggles.
    reset   = 1'b0;
    data_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data_in = ~data_in;
      @(posedge clk_32f_c);
      #1;
    end
    check_outs("t1_in_reset", 32'h0, 0, 0);
    reset = 1'b1;
    send_bits(32'h0, 31);
    check_outs("t1_31_zeros", 32'h0, 0, 0);

    foreach (vecs[k]) begin
      if (vecs[k].do_reset) apply_reset();
      send_bits(vecs[k].bits, vecs[k].nbits);
      check_outs(vecs[k].name, vecs[k].exp_data, vecs[k].exp_valid, vecs[k].exp_active);
      $display("vec %0d %s: bits=%h n=%0d data_out=%h valid_out=%b active=%b",
               k, vecs[k].name, vecs[k].bits, vecs[k].nbits, data_out, valid_out, active);
    end

    // Mid-word asynchronous reset while ACTIVE and valid.
    send_bits(32'h3A5, 10);
    check_outs("t6_before_rst", 32'hA5A55A5A, 1, 1);
    #2;
    reset = 1'b0;
    #1;
    check_outs("t6_async_rst", 32'h0, 0, 0);
    repeat (2) @(posedge clk_32f_c);
    #1;
    reset = 1'b1;
    send_bits(COM, 32);
    send_bits(COM, 32);
    send_bits(COM, 32);
    send_bits(COM >> 1, 31);
    check_outs("t6_relock_pre", 32'h0, 0, 0);
    send_bits(32'h0, 1);
    check_outs("t6_relock", 32'h0, 0, 1);
    send_bits(32'h0F0F1234, 32);
    check_outs("t6_data", 32'h0F0F1234, 1, 1);
    $display("t6 async reset/relock: data_out=%h valid_out=%b active=%b", data_out, valid_out, active);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_serial_to_parallel_c

// File: doc/serial_to_parallel_c.md
Name: serial_to_parallel_c

Overview:
Per-lane receive deserializer that sits directly upstream of the byte un-striping stage. It takes one serial bit per clock, finds the 32-bit word boundary by hunting for a COM idle pattern, and declares the lane active after COM_COUNT consecutive aligned COM words. Once active, it emits each completed 32-bit word with a valid flag. These outputs become the lane_N / valid_N inputs of the un-striping block. Two instances are used, one per lane.

Parameters:
WIDTH, 32, deserialized word width in bits (also bits per word period)
COM_WORD, 32'hBCBCBCBC, idle/alignment word (four 0xBC COM symbols)
COM_COUNT, 4, consecutive aligned COM words required to enter ACTIVE

Ports:
clk_32f_c  input  1  bit clock, one serial bit per rising edge
reset  input  1  asynchronous, active-low reset
data_in  input  1  serial data, MSB of each word first
data_out  output  WIDTH  last completed data word; 0 when idle or not active
valid_out  output  1  1 while data_out holds a non-COM word received in ACTIVE
active  output  1  1 while lane is aligned (state ACTIVE)

Behaviour:
- Interface (already decided): single clock clk_32f_c; reset is asynchronous, active-low.
- Reset (reset==0, any time, including mid-word): state=SEARCH, shift reg=0, bit_cnt=0, com_cnt=0, data_out=0, valid_out=0, active=0. Outputs drop immediately, without waiting for a clock edge.
- Shift register: sr_next = {sr[WIDTH-2:0], data_in}, updated every edge while out of reset.
- bit_cnt (0..WIDTH-1) counts bits of the current word. A word "completes" on the edge where bit_cnt==WIDTH-1; the word is sr_next; bit_cnt then wraps to 0.
- State SEARCH:
  - Bit-granular hunt; bit_cnt is ignored.
  - Every edge, compare sr_next with COM_WORD.
  - On match: com_cnt<=1, bit_cnt<=0, go to LOCKING.
  - After reset, the earliest possible match is on the 32nd bit.
- State LOCKING, at each word completion:
  - Word==COM_WORD and com_cnt+1==COM_COUNT: go to ACTIVE; active<=1 on this edge.
  - Word==COM_WORD otherwise: com_cnt++.
  - Word!=COM_WORD: com_cnt<=0, go to SEARCH (alignment lost). The next hunt starts with the following bit.
  - data_out and valid_out stay 0.
- State ACTIVE, at each word completion (registered on the same edge, zero extra latency):
  - Word==COM_WORD: data_out<=0, valid_out<=0.
  - Otherwise: data_out<=word, valid_out<=1.
  - Outputs hold for the full WIDTH-cycle word period, so the downstream clk_f/clk_2f stages sample them stably.
- ACTIVE is sticky until reset; there is no in-band loss-of-lock detection.
- COM_COUNT==1: the SEARCH match goes directly to ACTIVE.
- Counter widths: bit_cnt is $clog2(WIDTH) bits; com_cnt is $clog2(COM_COUNT+1) bits, with no overflow in legal operation.

Decomposition:
- Shared package rx_pkg holds:
  - the state enum (SEARCH=2'd0, LOCKING=2'd1, ACTIVE=2'd2);
  - COM_SYMBOL=8'hBC;
  - the default COM_WORD;
  - default COM_COUNT.
  The parallel-to-serial transmitter uses the same package.
- One natural sub-module: com_detector (shift register plus COM_WORD comparator, outputs sr_next and a match flag). The FSM, counters and output registers stay in the top module.

Test Plan:
1. Hold reset=0 for 5 edges while data_in toggles -> data_out=0, valid_out=0, active=0. Release reset, drive 31 zero bits -> still all 0.
2. Send 4 aligned COM words (128 bits) -> active rises on the edge sampling bit 128. Then send 32'hDEADBEEF -> on bit 160, data_out=32'hDEADBEEF and valid_out=1, held 32 cycles.
3. Send 5 random bits, then 4 COM words, then 32'h12345678 -> lock is achieved regardless of offset; data_out=32'h12345678, valid_out=1.
4. Send 2 COM words, then 32'h00FF00FF, then 4 COM words -> returns to SEARCH after the bad word; active rises only at the end of the final 4 COM words.
5. In ACTIVE, send 32'hCAFEF00D then COM_WORD -> first the data word with valid_out=1; after the next 32 bits, data_out=0 and valid_out=0, active stays 1.
6. Assert reset mid-word while ACTIVE with valid_out=1 -> all outputs go to 0 asynchronously. After release, relock requires 4 fresh COM words.
